// File: rtl/bf_pkg.sv
// Shared definitions for the delay-and-sum beamformer: width derivations,
// the signed sample type and the supported channel ceiling.
package bf_pkg;

  localparam int MAX_MICS       = 32;
  localparam int DEFAULT_DATA_W = 8;

  typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

  // Width needed to hold a delay value in 0..max_delay.
  function automatic int calc_dly_w(input int max_delay);
    return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
  endfunction

  // Width that holds the sum of num_mics signed data_w operands without overflow.
  function automatic int calc_sum_w(input int data_w, input int num_mics);
    return data_w + $clog2(num_mics);
  endfunction

  // Width that holds a count of 0..num_mics enabled channels.
  function automatic int calc_cnt_w(input int num_mics);
    return $clog2(num_mics + 1);
  endfunction

endpackage

// File: rtl/bf_delay_line.sv
// One channel's circular sample history plus the combinational tap read.
// Delay 0 bypasses the ring and returns the incoming sample; a delay that
// reaches further back than the samples written since reset returns 0.
module bf_delay_line
  import bf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_DELAY = 79,
  parameter int DLY_W     = calc_dly_w(MAX_DELAY)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [DLY_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DLY_W-1:0]  rd_dly,
  input  logic [DLY_W-1:0]  fill,
  output logic [DATA_W-1:0] tap
);

  localparam int DEPTH = MAX_DELAY + 1;

  logic [DATA_W-1:0] ring [DEPTH];
  logic [DLY_W-1:0]  rd_addr;

  // History storage; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ring[wr_ptr] <= wr_data;
    end
  end

  // Slot written rd_dly samples ago, wrapping around the ring (modulo DEPTH).
  always_comb begin
    if (wr_ptr >= rd_dly) begin
      rd_addr = wr_ptr - rd_dly;
    end else begin
      rd_addr = wr_ptr + DLY_W'(DEPTH) - rd_dly;
    end
  end

  // Select bypass, ring read, or zero when the history is not yet deep enough.
  always_comb begin
    tap = '0;
    if (rd_dly == '0) begin
      tap = wr_data;
    end else if (rd_dly <= fill) begin
      tap = ring[rd_addr];
    end
  end

endmodule

// File: rtl/beamformer_ds.sv
// Parametrised delay-and-sum beamformer. Per-channel delays are written into
// shadow registers and applied atomically on the first sample after a commit.
// Two-cycle pipeline: stage 1 registers the taps, stage 2 the summed result.
// Optional feature macro BF_CHAN_MASK_EN adds a per-sample channel mask input
// and an enabled-channel count output aligned with out_valid.
module beamformer_ds
  import bf_pkg::*;
#(
  parameter int NUM_MICS  = 9,
  parameter int DATA_W    = 8,
  parameter int MAX_DELAY = 79,
  parameter int DLY_W     = calc_dly_w(MAX_DELAY),
  parameter int SUM_W     = calc_sum_w(DATA_W, NUM_MICS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic [NUM_MICS*DATA_W-1:0]   sample_in,
  input  logic                         dly_wr_valid,
  output logic                         dly_wr_ready,
  input  logic [$clog2(NUM_MICS)-1:0]  dly_wr_idx,
  input  logic [DLY_W-1:0]             dly_wr_val,
  input  logic                         dly_commit,
  output logic                         commit_pending,
  output logic                         dly_err,
`ifdef BF_CHAN_MASK_EN
  input  logic [NUM_MICS-1:0]          chan_mask,
  output logic [$clog2(NUM_MICS+1)-1:0] active_count,
`endif
  output logic                         out_valid,
  output logic [SUM_W-1:0]             out_data
);

  localparam int CNT_W = calc_cnt_w(NUM_MICS);

  logic [DLY_W-1:0]  wr_ptr;
  logic [DLY_W-1:0]  fill;
  logic [DLY_W-1:0]  shadow_dly  [NUM_MICS];
  logic [DLY_W-1:0]  active_dly  [NUM_MICS];
  logic [DLY_W-1:0]  shadow_next [NUM_MICS];
  logic [DLY_W-1:0]  eff_dly     [NUM_MICS];
  logic [DATA_W-1:0] tap         [NUM_MICS];
  logic [DATA_W-1:0] tap_q       [NUM_MICS];
  logic              wr_accept;
  logic              wr_bad;
  logic              apply_commit;
  logic              stage1_valid;
  logic [SUM_W-1:0]  tree_sum;

`ifdef BF_CHAN_MASK_EN
  logic [CNT_W-1:0]  mask_count;
  logic [CNT_W-1:0]  count_q;
`endif

  assign dly_wr_ready = !commit_pending;
  assign wr_accept    = dly_wr_valid && dly_wr_ready;
  assign wr_bad       = (32'(dly_wr_idx) >= NUM_MICS) || (32'(dly_wr_val) > MAX_DELAY);

  // A commit takes effect on the edge of the first sample at or after the request.
  assign apply_commit = sample_valid && (commit_pending || dly_commit);

  // Shadow set as it will be after this edge, so a same-cycle write joins a commit.
  always_comb begin
    for (int i = 0; i < NUM_MICS; i++) begin
      shadow_next[i] = shadow_dly[i];
      if (wr_accept && !wr_bad && (32'(dly_wr_idx) == i)) begin
        shadow_next[i] = dly_wr_val;
      end
    end
  end

  // A pending commit hands the first following sample the new set; a commit
  // arriving together with a sample leaves that sample on the old set.
  always_comb begin
    for (int i = 0; i < NUM_MICS; i++) begin
      eff_dly[i] = commit_pending ? shadow_dly[i] : active_dly[i];
    end
  end

  // Shadow and active delay registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MICS; i++) begin
        shadow_dly[i] <= '0;
        active_dly[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MICS; i++) begin
        shadow_dly[i] <= shadow_next[i];
        if (apply_commit) begin
          active_dly[i] <= shadow_next[i];
        end
      end
    end
  end

  // Commit handshake and sticky error flag for dropped out-of-range writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pending <= 1'b0;
      dly_err        <= 1'b0;
    end else begin
      if (apply_commit) begin
        commit_pending <= 1'b0;
      end else if (dly_commit) begin
        commit_pending <= 1'b1;
      end
      if (wr_accept && wr_bad) begin
        dly_err <= 1'b1;
      end
    end
  end

  // Shared ring write pointer and saturating count of samples held in history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (sample_valid) begin
      if (wr_ptr == DLY_W'(MAX_DELAY)) begin
        wr_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fill != DLY_W'(MAX_DELAY)) begin
        fill <= fill + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_MICS; g++) begin : g_chan
    bf_delay_line #(
      .DATA_W    (DATA_W),
      .MAX_DELAY (MAX_DELAY),
      .DLY_W     (DLY_W)
    ) u_line (
      .clk     (clk),
      .wr_en   (sample_valid),
      .wr_ptr  (wr_ptr),
      .wr_data (sample_in[g*DATA_W +: DATA_W]),
      .rd_dly  (eff_dly[g]),
      .fill    (fill),
      .tap     (tap[g])
    );
  end

`ifdef BF_CHAN_MASK_EN
  // Number of channels enabled for the current sample.
  always_comb begin
    mask_count = '0;
    for (int i = 0; i < NUM_MICS; i++) begin
      mask_count = mask_count + CNT_W'(chan_mask[i]);
    end
  end
`endif

  // Stage 1: capture each channel's tap for the incoming sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_valid <= 1'b0;
      for (int i = 0; i < NUM_MICS; i++) begin
        tap_q[i] <= '0;
      end
`ifdef BF_CHAN_MASK_EN
      count_q <= '0;
`endif
    end else begin
      stage1_valid <= sample_valid;
      if (sample_valid) begin
        for (int i = 0; i < NUM_MICS; i++) begin
`ifdef BF_CHAN_MASK_EN
          tap_q[i] <= chan_mask[i] ? tap[i] : '0;
`else
          tap_q[i] <= tap[i];
`endif
        end
`ifdef BF_CHAN_MASK_EN
        count_q <= mask_count;
`endif
      end
    end
  end

  // Adder tree over the sign-extended stage 1 taps.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < NUM_MICS; i++) begin
      tree_sum = tree_sum + {{(SUM_W-DATA_W){tap_q[i][DATA_W-1]}}, tap_q[i]};
    end
  end

  // Stage 2: register the sum and its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef BF_CHAN_MASK_EN
      active_count <= '0;
`endif
    end else begin
      out_valid <= stage1_valid;
      if (stage1_valid) begin
        out_data <= tree_sum;
`ifdef BF_CHAN_MASK_EN
        active_count <= count_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_beamformer_ds.sv
// Self-checking bench for beamformer_ds: directed steps with random samples,
// compared against a sample-history reference model of delay-and-sum.
module tb_beamformer_ds;
  import bf_pkg::*;

  localparam int NUM_MICS  = 9;
  localparam int DATA_W    = 8;
  localparam int MAX_DELAY = 79;
  localparam int DLY_W     = calc_dly_w(MAX_DELAY);
  localparam int SUM_W     = calc_sum_w(DATA_W, NUM_MICS);
  localparam int IDX_W     = $clog2(NUM_MICS);

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       sample_valid = 1'b0;
  logic [NUM_MICS*DATA_W-1:0] sample_in = '0;
  logic                       dly_wr_valid = 1'b0;
  logic                       dly_wr_ready;
  logic [IDX_W-1:0]           dly_wr_idx = '0;
  logic [DLY_W-1:0]           dly_wr_val = '0;
  logic                       dly_commit = 1'b0;
  logic                       commit_pending;
  logic                       dly_err;
  logic                       out_valid;
  logic signed [SUM_W-1:0]    out_data;
`ifdef BF_CHAN_MASK_EN
  logic [NUM_MICS-1:0]        chan_mask = '1;
  logic [$clog2(NUM_MICS+1)-1:0] active_count;
`endif

  always #5 clk = ~clk;

  beamformer_ds #(
    .NUM_MICS  (NUM_MICS),
    .DATA_W    (DATA_W),
    .MAX_DELAY (MAX_DELAY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_valid   (sample_valid),
    .sample_in      (sample_in),
    .dly_wr_valid   (dly_wr_valid),
    .dly_wr_ready   (dly_wr_ready),
    .dly_wr_idx     (dly_wr_idx),
    .dly_wr_val     (dly_wr_val),
    .dly_commit     (dly_commit),
    .commit_pending (commit_pending),
    .dly_err        (dly_err),
`ifdef BF_CHAN_MASK_EN
    .chan_mask      (chan_mask),
    .active_count   (active_count),
`endif
    .out_valid      (out_valid),
    .out_data       (out_data)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: full sample history since reset per channel.
  int cur_x [NUM_MICS];
  int hist  [NUM_MICS][$];
  int m_act [NUM_MICS];
  int m_shd [NUM_MICS];
  bit m_pend;
  bit m_err;
  int n_seen;
  bit exp_prev_v;
  int exp_prev_d;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    for (int ch = 0; ch < NUM_MICS; ch++) begin
      hist[ch].delete();
      m_act[ch] = 0;
      m_shd[ch] = 0;
    end
    m_pend     = 1'b0;
    m_err      = 1'b0;
    n_seen     = 0;
    exp_prev_v = 1'b0;
    exp_prev_d = 0;
  endtask

  // One clock cycle of stimulus; checks the outputs after the edge.
  task automatic applyStimulus(input bit sv, input bit wv, input int widx,
                               input int wval, input bit cm);
    int y;
    int d;
    y = 0;
    sample_valid = sv;
    dly_wr_valid = wv;
    dly_wr_idx   = IDX_W'(widx);
    dly_wr_val   = DLY_W'(wval);
    dly_commit   = cm;
    for (int ch = 0; ch < NUM_MICS; ch++) begin
      sample_in[ch*DATA_W +: DATA_W] = cur_x[ch][DATA_W-1:0];
    end

    // y[n] = sum x_i[n - d_i]; samples before reset do not exist.
    if (sv) begin
      for (int ch = 0; ch < NUM_MICS; ch++) begin
        d = m_pend ? m_shd[ch] : m_act[ch];
        if (d == 0) y += cur_x[ch];
        else if (d <= n_seen) y += hist[ch][n_seen - d];
        hist[ch].push_back(cur_x[ch]);
      end
      n_seen++;
    end
    if (wv && !m_pend) begin
      if (widx >= NUM_MICS || wval > MAX_DELAY) m_err = 1'b1;
      else m_shd[widx] = wval;
    end
    if (sv && (m_pend || cm)) begin
      m_act  = m_shd;
      m_pend = 1'b0;
    end else if (cm) begin
      m_pend = 1'b1;
    end

    @(posedge clk);
    #1;
    checkOutput("out_valid", out_valid, exp_prev_v);
    if (exp_prev_v) begin
      checkOutput("out_data", out_data, exp_prev_d);
`ifdef BF_CHAN_MASK_EN
      checkOutput("active_count", active_count, NUM_MICS);
`endif
    end
    checkOutput("dly_wr_ready", dly_wr_ready, !m_pend);
    checkOutput("commit_pending", commit_pending, m_pend);
    checkOutput("dly_err", dly_err, m_err);
    exp_prev_v = sv;
    exp_prev_d = y;
  endtask

  task automatic randomSamples();
    for (int ch = 0; ch < NUM_MICS; ch++) begin
      cur_x[ch] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic fillSamples(input int v);
    for (int ch = 0; ch < NUM_MICS; ch++) cur_x[ch] = v;
  endtask

  initial begin
    sample_t ramp_s;
    int      ramp_k;
    resetModel();
    fillSamples(0);

    // Reset state.
    #2;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_ready", dly_wr_ready, 1);
    checkOutput("reset_pending", commit_pending, 0);
    checkOutput("reset_err", dly_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero-delay sum and single-cycle out_valid pulse.
    fillSamples(10);
    applyStimulus(1, 0, 0, 0, 0);
    fillSamples(0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("zero_delay_valid", out_valid, 1);
    checkOutput("zero_delay_sum", out_data, 90);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("zero_delay_pulse_end", out_valid, 0);

    // Extremes.
    fillSamples(-128);
    applyStimulus(1, 0, 0, 0, 0);
    fillSamples(127);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("min_sum", out_data, -1152);
    fillSamples(0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("max_sum", out_data, 1143);
    for (int k = 0; k < 10; k++) begin
      randomSamples();
      applyStimulus($urandom_range(0, 3) != 0, 0, 0, 0, 0);
    end

    // Per-channel delay with a commit left pending across idle cycles.
    fillSamples(0);
    applyStimulus(0, 1, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 5, 0);
    applyStimulus(0, 0, 0, 0, 1);
    cur_x[0] = 100;
    applyStimulus(1, 0, 0, 0, 0);
    cur_x[0] = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus($urandom_range(0, 2) != 0, 0, 0, 0, 0);
    end

    // Atomic commit held together with a sample, with a write in the same cycle.
    for (int k = 0; k < 5; k++) begin
      randomSamples();
      applyStimulus(1, 0, 0, 0, 0);
    end
    randomSamples();
    applyStimulus(1, 1, 2, 7, 0);
    randomSamples();
    applyStimulus(1, 1, 4, 1, 1);
    for (int k = 0; k < 8; k++) begin
      randomSamples();
      applyStimulus(1, 0, 0, 0, 0);
    end

    // Out-of-range writes are dropped and latch the error flag.
    applyStimulus(0, 1, 9, 2, 0);
    applyStimulus(0, 1, 3, 80, 0);
    applyStimulus(0, 1, 15, 79, 0);
    randomSamples();
    applyStimulus(1, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      randomSamples();
      applyStimulus(1, 0, 0, 0, 0);
    end

    // Random writes, commits and sample gaps.
    for (int k = 0; k < 150; k++) begin
      randomSamples();
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 85)),
                    $urandom_range(0, 7) == 0);
    end

    // Reset mid-stream.
    randomSamples();
    applyStimulus(1, 0, 0, 0, 0);
    randomSamples();
    applyStimulus(1, 0, 0, 0, 0);
    sample_valid = 1'b0;
    dly_wr_valid = 1'b0;
    dly_commit   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_ready", dly_wr_ready, 1);
    checkOutput("midreset_pending", commit_pending, 0);
    checkOutput("midreset_err", dly_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();
    for (int k = 0; k < 5; k++) begin
      randomSamples();
      applyStimulus(1, 0, 0, 0, 0);
    end

    // Maximum delay with a ramp: ring wrap and zero output before fill.
    $display("[TB] ramp through maximum delay");
    resetModel();
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fillSamples(0);
    applyStimulus(0, 1, 0, MAX_DELAY, 0);
    ramp_k = 0;
    for (int k = 0; k < 200; k++) begin
      bit sv;
      sv = ($urandom_range(0, 9) != 0) || (k == 0);
      ramp_s = sample_t'(ramp_k);
      cur_x[0] = int'(ramp_s);
      for (int ch = 1; ch < NUM_MICS; ch++) begin
        cur_x[ch] = int'($urandom_range(0, 6)) - 3;
      end
      applyStimulus(sv, 0, 0, 0, k == 0);
      if (sv) ramp_k++;
    end

    fillSamples(0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
